// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the ARM-subset multicycle control unit.
// Optional BL support is selected with ARM_CTRL_BL_EN.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_ORR  = 3'd3;
  localparam logic [2:0] ALU_MOVB = 3'd4;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_RD2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  typedef struct packed {
    logic       vld;
    logic [2:0] alu;
    logic       cmp;
    logic       cv;
  } dp_dec_t;

  // cv marks ops whose carry/overflow are meaningful
  function automatic dp_dec_t dp_decode(
    input logic [3:0] cmd
  );
    dp_dec_t d;
    d = '{vld: 1'b1, alu: ALU_ADD,
          cmp: 1'b0, cv: 1'b0};
    unique case (cmd)
      CMD_ADD: d.cv = 1'b1;
      CMD_SUB: begin
        d.alu = ALU_SUB;
        d.cv  = 1'b1;
      end
      CMD_AND: d.alu = ALU_AND;
      CMD_ORR: d.alu = ALU_ORR;
      CMD_CMP: begin
        d.alu = ALU_SUB;
        d.cmp = 1'b1;
        d.cv  = 1'b1;
      end
      CMD_MOV: d.alu = ALU_MOVB;
      default: d.vld = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/arm_cond_check.sv
// ARM condition-code evaluation against an NZCV flag vector.
// Combinational; 1111 is treated as never.
module arm_cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n;
  logic z;
  logic c;
  logic v;
  logic ge;

  assign {n, z, c, v} = Flags;
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle Moore control FSM with NZCV flag register.
// Define ARM_CTRL_BL_EN to enable BL (link write to R14).
module arm_multicycle_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int         ALUCTRL_W  = 3,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 RegWrite,
  output logic                 LinkWrite,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags
);

  state_t     state;
  dp_dec_t    dp;
  logic       cond_ex;
  logic       set_flags;
  logic       rd_pc;
  logic       link_en;
  logic [2:0] alu_op;
  logic       pc_w;
  logic       ir_w;
  logic       mem_w;
  logic       reg_w;
  logic       link_w;

  arm_cond_check u_cond (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (cond_ex)
  );

  assign dp        = dp_decode(Funct[4:1]);
  assign set_flags = dp.vld & (Funct[0] | dp.cmp);
  assign rd_pc     = (Rd == 4'd15);

`ifdef ARM_CTRL_BL_EN
  assign link_en = Funct[4];
`else
  assign link_en = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
      Flags <= FLAG_RESET;
    end else begin
      unique case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (!cond_ex) begin
            state <= S_FETCH;
          end else begin
            unique case (Op)
              OP_DP:
                state <= Funct[5] ? S_EXECI
                                  : S_EXECR;
              OP_MEM:  state <= S_MEMADR;
              OP_BR:   state <= S_BRANCH;
              default: state <= S_FETCH;
            endcase
          end
        end
        S_EXECR, S_EXECI: begin
          if (dp.vld && !dp.cmp)
            state <= S_ALUWB;
          else
            state <= S_FETCH;
          // logical ops keep the previous C and V
          if (set_flags) begin
            Flags[3:2] <= ALUFlags[3:2];
            if (dp.cv)
              Flags[1:0] <= ALUFlags[1:0];
          end
        end
        S_MEMADR:
          state <= Funct[0] ? S_MEMRD
                            : S_MEMWR;
        S_MEMRD: state <= S_MEMWB;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_w      = 1'b0;
    ir_w      = 1'b0;
    mem_w     = 1'b0;
    reg_w     = 1'b0;
    link_w    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ImmSrc    = IMM_8;
    RegSrc    = 2'b00;
    alu_op    = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        ir_w      = 1'b1;
        pc_w      = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALU;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_4;
        RegSrc  = {Op == OP_MEM, Op == OP_BR};
      end
      S_EXECR: alu_op = dp.alu;
      S_EXECI: begin
        ALUSrcB = SRCB_IMM;
        alu_op  = dp.alu;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
        pc_w  = rd_pc;
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_12;
      end
      S_MEMRD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        reg_w     = 1'b1;
        pc_w      = rd_pc;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
        RegSrc = 2'b10;
      end
      S_BRANCH: begin
        RegSrc    = 2'b01;
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_24;
        ResultSrc = RES_ALU;
        pc_w      = 1'b1;
        link_w    = link_en;
      end
      default: ;
    endcase
  end

  // strobes are held off for as long as reset is low
  assign PCWrite    = pc_w & reset;
  assign IRWrite    = ir_w & reset;
  assign MemWrite   = mem_w & reset;
  assign RegWrite   = reg_w & reset;
  assign LinkWrite  = link_w & reset;
  assign ALUControl = ALUCTRL_W'(alu_op);

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Scoreboard bench for arm_multicycle_ctrl.
// Honours ARM_CTRL_BL_EN for the link-write expectation.
module tb_arm_multicycle_ctrl;

  localparam int W = 3;

  localparam int SF   = 0;
  localparam int SD   = 1;
  localparam int SMA  = 2;
  localparam int SMR  = 3;
  localparam int SMW  = 4;
  localparam int SMWR = 5;
  localparam int SER  = 6;
  localparam int SEI  = 7;
  localparam int SWB  = 8;
  localparam int SBR  = 9;

`ifdef ARM_CTRL_BL_EN
  localparam bit BL_EN = 1'b1;
`else
  localparam bit BL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   Cond = 4'he;
  logic [1:0]   Op = 2'b00;
  logic [5:0]   Funct = '0;
  logic [3:0]   Rd = '0;
  logic [3:0]   ALUFlags = '0;
  logic         PCWrite;
  logic         AdrSrc;
  logic         MemWrite;
  logic         IRWrite;
  logic [1:0]   ResultSrc;
  logic         ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ImmSrc;
  logic [1:0]   RegSrc;
  logic         RegWrite;
  logic         LinkWrite;
  logic [W-1:0] ALUControl;
  logic [3:0]   Flags;

  arm_multicycle_ctrl #(
    .ALUCTRL_W  (W),
    .FLAG_RESET (4'b0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .LinkWrite  (LinkWrite),
    .ALUControl (ALUControl),
    .Flags      (Flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           st;
    logic [4:0]   strb;
    bit           chk_alu;
    logic [W-1:0] alu;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] mflags = 4'b0000;
  int         n_chk = 0;
  int         n_fail = 0;

  function automatic int classify();
    if (IRWrite)                 return SF;
    if (MemWrite)                return SMWR;
    if (ResultSrc == 2'b01)      return SMW;
    if (AdrSrc)                  return SMR;
    if (ImmSrc == 2'b10)         return SBR;
    if (ImmSrc == 2'b01)         return SMA;
    if (RegWrite)                return SWB;
    if (ALUSrcA)                 return SD;
    if (ALUSrcB == 2'b01)        return SEI;
    return SER;
  endfunction

  function automatic logic [4:0] strobes();
    return {PCWrite, IRWrite, MemWrite,
            RegWrite, LinkWrite};
  endfunction

  function automatic bit m_cond(
    input logic [3:0] c,
    input logic [3:0] f
  );
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void push(
    input int           st,
    input logic [4:0]   s,
    input bit           ca,
    input logic [W-1:0] a
  );
    exp_t e;
    e.st = st;
    e.strb = s;
    e.chk_alu = ca;
    e.alu = a;
    sbq.push_back(e);
  endfunction

  // Called with the DUT in FETCH; returns with the DUT in the next FETCH.
  task automatic run_instr(
    input string      name,
    input logic [3:0] c,
    input logic [1:0] op,
    input logic [5:0] f,
    input logic [3:0] rd,
    input logic [3:0] af
  );
    bit           ok;
    bit           vld, cmp, cv;
    logic [W-1:0] a;
    logic [3:0]   nf;
    exp_t         e;
    int           got;
    ok = m_cond(c, mflags);
    nf = mflags;
    vld = 1; cmp = 0; cv = 0; a = '0;
    case (f[4:1])
      4'b0100: cv = 1;
      4'b0010: begin a = 1; cv = 1; end
      4'b0000: a = 2;
      4'b1100: a = 3;
      4'b1010: begin a = 1; cv = 1; cmp = 1; end
      4'b1101: a = 4;
      default: vld = 0;
    endcase
    push(SF, 5'b11000, 0, '0);
    push(SD, 5'b00000, 0, '0);
    if (ok) begin
      case (op)
        2'b00: begin
          push(f[5] ? SEI : SER, 5'b00000, vld, a);
          if (vld && !cmp)
            push(SWB, {rd == 4'd15, 3'b001, 1'b0}, 0, '0);
          if (vld && (f[0] || cmp)) begin
            nf[3:2] = af[3:2];
            if (cv) nf[1:0] = af[1:0];
          end
        end
        2'b01: begin
          push(SMA, 5'b00000, 0, '0);
          if (f[0]) begin
            push(SMR, 5'b00000, 0, '0);
            push(SMW, {rd == 4'd15, 3'b001, 1'b0}, 0, '0);
          end else begin
            push(SMWR, 5'b00100, 0, '0);
          end
        end
        2'b10: push(SBR, {4'b1000, BL_EN && f[4]}, 0, '0);
        default: ;
      endcase
    end
    Cond = c; Op = op; Funct = f;
    Rd = rd; ALUFlags = af;
    while (sbq.size() > 0) begin
      @(negedge clk);
      e = sbq.pop_front();
      got = classify();
      n_chk++;
      if (got !== e.st) begin
        n_fail++;
        $display("FAIL %s state: got %0d want %0d",
                 name, got, e.st);
      end
      n_chk++;
      if (strobes() !== e.strb) begin
        n_fail++;
        $display("FAIL %s strobes st%0d: got %b want %b",
                 name, e.st, strobes(), e.strb);
      end
      if (e.chk_alu) begin
        n_chk++;
        if (ALUControl !== e.alu) begin
          n_fail++;
          $display("FAIL %s alu: got %0d want %0d",
                   name, ALUControl, e.alu);
        end
      end
      @(posedge clk);
      #1;
    end
    mflags = nf;
    n_chk++;
    if (Flags !== mflags) begin
      n_fail++;
      $display("FAIL %s flags: got %b want %b",
               name, Flags, mflags);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (strobes() !== 5'b0) begin
        n_fail++;
        $display("FAIL reset strobes: got %b want 00000",
                 strobes());
      end
      n_chk++;
      if (Flags !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset flags: got %b want 0000", Flags);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    mflags = 4'b0000;
    #1;
    n_chk++;
    if (!(IRWrite === 1'b1 && PCWrite === 1'b1)) begin
      n_fail++;
      $display("FAIL first fetch: got IR=%b PC=%b want 1 1",
               IRWrite, PCWrite);
    end
  endtask

  task automatic test_dataproc();
    run_instr("ADDS imm", 4'he, 2'b00, 6'b101001, 4'd1, 4'b0100);
    run_instr("ADD noS", 4'he, 2'b00, 6'b101000, 4'd2, 4'b1111);
    run_instr("ORR imm", 4'he, 2'b00, 6'b111000, 4'd3, 4'b1000);
    run_instr("SUBS reg", 4'he, 2'b00, 6'b000101, 4'd4, 4'b0011);
    run_instr("ANDS", 4'he, 2'b00, 6'b000001, 4'd5, 4'b1000);
    run_instr("MOV pc", 4'he, 2'b00, 6'b111010, 4'd15, 4'b0000);
  endtask

  task automatic test_cmp_branch();
    run_instr("CMP r0", 4'he, 2'b00, 6'b010101, 4'd0, 4'b0110);
    run_instr("BNE", 4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000);
    run_instr("BEQ", 4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
  endtask

  task automatic test_cond_table();
    logic [3:0] fs[3];
    fs[0] = 4'b1001;
    fs[1] = 4'b1000;
    fs[2] = 4'b0010;
    foreach (fs[k]) begin
      run_instr("CMP set", 4'he, 2'b00, 6'b010101, 4'd0, fs[k]);
      for (int c = 0; c < 16; c++)
        run_instr("Bcond", 4'(c), 2'b10, 6'b000000, 4'd0, 4'b0);
    end
  endtask

  task automatic test_mem();
    run_instr("LDR", 4'he, 2'b01, 6'b011001, 4'd3, 4'b0000);
    run_instr("STR", 4'he, 2'b01, 6'b011000, 4'd3, 4'b0000);
    run_instr("LDR pc", 4'he, 2'b01, 6'b011001, 4'd15, 4'b0000);
  endtask

  task automatic test_bl();
    run_instr("BL", 4'he, 2'b10, 6'b010000, 4'd0, 4'b0000);
  endtask

  task automatic test_back_to_back();
    run_instr("undef op", 4'he, 2'b11, 6'b000000, 4'd0, 4'b0000);
    run_instr("never", 4'hf, 2'b00, 6'b101001, 4'd1, 4'b1111);
    run_instr("CMP lt", 4'he, 2'b00, 6'b110101, 4'd0, 4'b1000);
    run_instr("ADDLT", 4'hb, 2'b00, 6'b101001, 4'd6, 4'b0100);
    run_instr("ADDGE", 4'ha, 2'b00, 6'b101001, 4'd6, 4'b0001);
  endtask

  task automatic test_reset_in_memwr();
    run_instr("CMP pre", 4'he, 2'b00, 6'b010101, 4'd0, 4'b0110);
    Cond = 4'he; Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (classify() !== SMWR) begin
      n_fail++;
      $display("FAIL rst memwr reach: got %0d want %0d",
               classify(), SMWR);
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (strobes() !== 5'b0) begin
      n_fail++;
      $display("FAIL rst memwr strobes: got %b want 00000",
               strobes());
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    mflags = 4'b0000;
    #1;
    n_chk++;
    if (classify() !== SF) begin
      n_fail++;
      $display("FAIL rst memwr next: got %0d want %0d",
               classify(), SF);
    end
    n_chk++;
    if (Flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst memwr flags: got %b want 0000", Flags);
    end
    run_instr("post rst", 4'he, 2'b00, 6'b101001, 4'd1, 4'b1000);
  endtask

  initial begin
    test_reset();
    test_dataproc();
    test_cmp_branch();
    test_cond_table();
    test_mem();
    test_bl();
    test_back_to_back();
    test_reset_in_memwr();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
